// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image and writes it into
// instruction memory, holding the processor in reset until the image has been verified.
module program_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // One extra bit so that a 16-bit length can be compared against MEM_BYTES = 65536.
  localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         idx_q, idx_d;
  logic [7:0]          sum_q, sum_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept;

  // in_ready_q always mirrors whether state_q is a receiving state, so this
  // never depends on in_valid through anything but the final AND.
  assign accept = in_valid && in_ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_LEN_LO: state_d = S_LEN_HI;
        S_LEN_HI: begin
          if ({1'b0, in_byte, len_q[7:0]} > MAX_LEN) begin
            state_d = S_ERR;
          end else if ({in_byte, len_q[7:0]} == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (idx_q == len_q - 16'd1) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM:  state_d = (in_byte == sum_q) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge that completes the transition.
  always_comb begin
    in_ready_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (accept) begin
      case (state_q)
        S_LEN_LO: len_d[7:0]  = in_byte;
        S_LEN_HI: len_d[15:8] = in_byte;
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(BASE_ADDR + 32'(idx_q));
          mem_wdata_d = in_byte;
          sum_d       = sum_q + in_byte;
          idx_d       = idx_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader upstream of the Y86-64 SEQ `top`; replaces `$readmemh` preloading of instruction memory on hardware.
- Accepts a framed image over a valid/ready byte interface: 16-bit length, payload, 8-bit checksum.
- Writes the payload into instruction memory byte by byte.
- Holds the processor in reset until a complete, checksum-correct image has been written; then releases it.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- MEM_BYTES, 1024, capacity in bytes; must satisfy MEM_BYTES <= 2^ADDR_W.
- BASE_ADDR, 0, address of the first payload byte.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  source presents in_byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_reset  out  1  reset to `top`; 1 = hold the processor in reset.
- done  out  1  image loaded and verified.
- error  out  1  load failed.

Behaviour:
- Transfer: a byte is accepted on a clock edge where in_valid && in_ready.
- Reset (reset=0, asynchronous):
  - state=LEN_LO; length, index and checksum cleared.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
  - in_ready goes high on the first edge after reset deasserts.
- Frame format, little-endian: LEN_LO, LEN_HI, then LEN payload bytes, then CSUM.
  - CSUM = 8-bit wrap-around sum of the payload bytes only.
- States:
  - LEN_LO: accept a byte → len[7:0]; go to LEN_HI.
  - LEN_HI: accept a byte → len[15:8]; then:
    - if {byte,len[7:0]} > MEM_BYTES → ERR;
    - else if length == 0 → CSUM;
    - else → DATA.
  - DATA: each accepted byte:
    - on the next edge, mem_we=1, mem_addr=BASE_ADDR+index (truncated to ADDR_W), mem_wdata=byte; single-cycle registered write;
    - sum += byte (mod 256); index++;
    - when index reaches len-1 on acceptance → CSUM.
  - CSUM: accept a byte; if it equals sum → DONE, else → ERR.
  - DONE: in_ready=0, done=1, cpu_reset=0. Sticky until reset.
  - ERR: in_ready=0, error=1, cpu_reset=1. Sticky until reset.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM.
  - It does not depend combinationally on in_valid.
  - Back-to-back acceptance at one byte per cycle is sustained.
- Stalls: in_valid=0 inserts idle cycles; state, index and sum hold; mem_we=0.
- mem_we is 0 in every cycle not immediately following a DATA acceptance.
- Memory write order:
  - The last payload write completes in the cycle after its acceptance, no later than the CSUM acceptance.
  - cpu_reset therefore never deasserts before the final write.
- Boundary cases:
  - length == MEM_BYTES is legal.
  - length == MEM_BYTES+1 → ERR with no memory write.
- Reset mid-load aborts immediately. Partially written memory is not erased; cpu_reset stays 1 until a new complete load finishes.
- done and error are never 1 simultaneously.
- Outputs are registered; no combinational path from in_* to mem_* or status outputs.

Test Plan:
- Nominal:
  - stream 05 00, 30 F0 0A 00 00, CSUM 2A;
  - → five writes: addr 0..4 = 30,F0,0A,00,00;
  - → done=1 and cpu_reset=0 the cycle after CSUM acceptance; error=0.
- Bad checksum: same frame with CSUM 2B → five writes occur, then error=1, cpu_reset=1, in_ready=0, done=0.
- Oversize:
  - length 01 04 (1025) → error=1 after LEN_HI acceptance, no mem_we ever;
  - length 00 04 (1024) of all 0x01 with CSUM 00 → 1024 writes, last at addr 0x3FF, done=1.
- Zero length: 00 00, CSUM 00 → done=1, no writes.
- Backpressure and gaps:
  - random in_valid gaps during the nominal frame → identical writes and result;
  - no write occurs in a gap cycle.
- Reset mid-DATA:
  - reset=0 after 2 payload bytes → immediate in_ready=0, cpu_reset=1, mem_we=0;
  - after release, the full nominal frame loads correctly and done=1.
